// File: rtl/segment_decode_monitor_if.sv
// Bus bundle for segment_decode_monitor.
// Optional macro: SEG_DECODE_STATS_EN adds upd_cnt/err_cnt.
// Signalling: seg_in is a free-running asynchronous level with no handshake.
// Every result output is a registered level, and each *_upd/*_valid/illegal/
// seq_err flag is a single-cycle pulse that the receiver must sample on the
// cycle it is high. The receiver has no ready or backpressure path.
interface segment_decode_monitor_if #(
    parameter int PERIOD_W = 25
);
    logic [7:0]          seg_in;
    logic [4:0]          data;
    logic                data_upd;
    logic                illegal;
    logic                seq_err;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic [1:0]          state_dbg;
`ifdef SEG_DECODE_STATS_EN
    logic [15:0]         upd_cnt;
    logic [15:0]         err_cnt;
`endif

    modport master (
        output seg_in,
        input  data, data_upd, illegal, seq_err, period, period_valid, state_dbg
`ifdef SEG_DECODE_STATS_EN
        , input upd_cnt, err_cnt
`endif
    );

    modport slave (
        input  seg_in,
        output data, data_upd, illegal, seq_err, period, period_valid, state_dbg
`ifdef SEG_DECODE_STATS_EN
        , output upd_cnt, err_cnt
`endif
    );
endinterface

// File: rtl/segment_decode_monitor.sv
// segment_decode_monitor: synchronises and filters a 7-segment bus, decodes the
// glyph (SEG[7] is value bit 4), checks +1 mod 32 stepping and measures the
// update period.
// Optional macro: SEG_DECODE_STATS_EN adds saturating update/error counters.
module segment_decode_monitor #(
    parameter int STABLE_CYCLES  = 4,
    parameter int PERIOD_W       = 25,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    segment_decode_monitor_if.slave bus
);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    STAB_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FIRST = 2'd1, ST_RUN = 2'd2} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_sync1, r_sync2, r_cand, r_last_pat;
    logic [CNT_W-1:0]    r_stab;
    logic [4:0]          r_data;
    logic                r_upd, r_ill, r_seq, r_pv;
    logic [PERIOD_W-1:0] r_period, r_pcnt;

    logic                w_accept, w_legal;
    logic [6:0]          w_segs;
    logic [3:0]          w_nib;
    logic [4:0]          w_value;
    logic [PERIOD_W:0]   w_pcnt_inc;
    logic [PERIOD_W-1:0] w_period_sat;
    logic                w_upd_nxt, w_ill_nxt, w_seq_nxt, w_pv_nxt;

    // The filter runs on raw synced bits; polarity only matters for decoding.
    assign w_accept     = (r_stab == STAB_MAX) && (r_cand != r_last_pat);
    assign w_segs       = SEG_ACTIVE_LOW ? ~r_cand[6:0] : r_cand[6:0];
    assign w_value      = {r_cand[7], w_nib};
    assign w_pcnt_inc   = {1'b0, r_pcnt} + {{PERIOD_W{1'b0}}, 1'b1};
    assign w_period_sat = w_pcnt_inc[PERIOD_W] ? PCNT_MAX : w_pcnt_inc[PERIOD_W-1:0];

    // Glyph to nibble decode; anything outside the hex set is illegal.
    always_comb begin
        w_legal = 1'b1;
        w_nib   = 4'h0;
        case (w_segs)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    // Next state and pulse decisions for an accepted pattern.
    always_comb begin
        w_state_nxt = r_state;
        w_upd_nxt   = 1'b0;
        w_ill_nxt   = 1'b0;
        w_seq_nxt   = 1'b0;
        w_pv_nxt    = 1'b0;
        if (w_accept) begin
            if (!w_legal) begin
                w_ill_nxt = 1'b1;
            end else begin
                w_upd_nxt = 1'b1;
                if (r_state == ST_EMPTY) begin
                    w_state_nxt = ST_FIRST;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_pv_nxt    = 1'b1;
                    w_seq_nxt   = (w_value != r_data + 5'd1);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Synchroniser, glitch filter and acceptance memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cand     <= '0;
            r_stab     <= '0;
            r_last_pat <= '0;
        end else begin
            r_sync1 <= bus.seg_in;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_stab <= '0;
            end else if (r_stab != STAB_MAX) begin
                r_stab <= r_stab + CNT_W'(1);
            end
            if (w_accept) r_last_pat <= r_cand;
        end
    end

    // Registered results, pulses and the period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_upd    <= 1'b0;
            r_ill    <= 1'b0;
            r_seq    <= 1'b0;
            r_pv     <= 1'b0;
            r_period <= '0;
            r_pcnt   <= '0;
        end else begin
            r_upd <= w_upd_nxt;
            r_ill <= w_ill_nxt;
            r_seq <= w_seq_nxt;
            r_pv  <= w_pv_nxt;
            if (w_upd_nxt) r_data   <= w_value;
            if (w_pv_nxt)  r_period <= w_period_sat;
            if (w_upd_nxt)
                r_pcnt <= '0;
            else if (r_state != ST_EMPTY && r_pcnt != PCNT_MAX)
                r_pcnt <= r_pcnt + PERIOD_W'(1);
        end
    end

`ifdef SEG_DECODE_STATS_EN
    logic [15:0] r_upd_cnt, r_err_cnt;

    // Saturating statistics; a cycle with both error kinds counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_upd_nxt && r_upd_cnt != 16'hFFFF) r_upd_cnt <= r_upd_cnt + 16'd1;
            if ((w_seq_nxt || w_ill_nxt) && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign bus.upd_cnt = r_upd_cnt;
    assign bus.err_cnt = r_err_cnt;
`endif

    assign bus.data         = r_data;
    assign bus.data_upd     = r_upd;
    assign bus.illegal      = r_ill;
    assign bus.seq_err      = r_seq;
    assign bus.period       = r_period;
    assign bus.period_valid = r_pv;
    assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_segment_decode_monitor.sv
// Self-checking bench for segment_decode_monitor (STABLE_CYCLES=4, active-low).
module tb_segment_decode_monitor;
    localparam int PW = 25;
    localparam int EW = 5 + 4 + PW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    segment_decode_monitor_if #(.PERIOD_W(PW)) bus ();

    segment_decode_monitor #(
        .STABLE_CYCLES(4), .PERIOD_W(PW), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // scoreboard state
    int n_checks = 0;
    int n_fail = 0;
    int pv_seen = 0;
    logic [EW-1:0] exp_q[$];
    logic       exp_have = 1'b0;
    logic [4:0] exp_data = '0;
    int         last_legal_cyc = 0;
    int         exp_upd_cnt = 0;
    int         exp_err_cnt = 0;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Common-anode segments, bit 7 carries value bit 4 uninverted.
    function automatic logic [7:0] enc(input logic [4:0] v);
        logic [6:0] g;
        g = glyph(v[3:0]);
        return {v[4], ~g};
    endfunction

    function automatic logic [EW-1:0] pack_ev(input logic [4:0] d, input logic u, input logic i,
                                              input logic s, input logic pv, input logic [PW-1:0] per);
        return {d, u, i, s, pv, (pv ? per : {PW{1'b0}})};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_legal(input logic [4:0] v);
        logic s, pv;
        logic [PW-1:0] per;
        s   = exp_have && (v != exp_data + 5'd1);
        pv  = exp_have;
        per = PW'(cyc - last_legal_cyc);
        exp_q.push_back(pack_ev(v, 1'b1, 1'b0, s, pv, per));
        exp_have = 1'b1;
        exp_data = v;
        last_legal_cyc = cyc;
    endtask

    task automatic send_legal(input logic [4:0] v, input int hold);
        bus.seg_in = enc(v);
        push_legal(v);
        tick(hold);
    endtask

    task automatic send_illegal(input logic [7:0] pat, input int hold);
        bus.seg_in = pat;
        exp_q.push_back(pack_ev(exp_data, 1'b0, 1'b1, 1'b0, 1'b0, '0));
        tick(hold);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, 64'(bus.data), 0);
        check({tag, "_pulses"}, 64'({bus.data_upd, bus.illegal, bus.seq_err, bus.period_valid}), 0);
        check({tag, "_period"}, 64'(bus.period), 0);
        check({tag, "_state"}, 64'(bus.state_dbg), 0);
`ifdef SEG_DECODE_STATS_EN
        check({tag, "_cnts"}, 64'({bus.upd_cnt, bus.err_cnt}), 0);
`endif
    endtask

    task automatic do_reset();
        bus.seg_in = 8'h00;
        rst_n = 1'b0;
        tick(3);
        check_zero("reset");
        exp_have = 1'b0;
        exp_data = '0;
        exp_upd_cnt = 0;
        exp_err_cnt = 0;
        rst_n = 1'b1;
        tick(10);
    endtask

    // monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        logic [EW-1:0] obs, expv;
        if (rst_n && (bus.data_upd || bus.illegal || bus.seq_err || bus.period_valid)) begin
            obs = pack_ev(bus.data, bus.data_upd, bus.illegal, bus.seq_err, bus.period_valid, bus.period);
            if (bus.period_valid) pv_seen++;
            check("event_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                check("event", 64'(obs), 64'(expv));
`ifdef SEG_DECODE_STATS_EN
                if (expv[PW+3]) exp_upd_cnt++;
                if (expv[PW+2] || expv[PW+1]) exp_err_cnt++;
                check("upd_cnt", 64'(bus.upd_cnt), 64'(exp_upd_cnt));
                check("err_cnt", 64'(bus.err_cnt), 64'(exp_err_cnt));
`endif
            end
        end
    end

    // directed sequence
    initial begin
        int lat;
        bit found;
        int pv_base;
        bus.seg_in = 8'h00;
        do_reset();

        // Latency from a change to the data_upd pulse
        bus.seg_in = enc(5'd0);
        push_legal(5'd0);
        lat = 0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.data_upd) found = 1'b1;
        end
        check("latency", 64'(lat), 7);
        check("first_data", 64'(bus.data), 0);
        check("first_seq_err", 64'(bus.seq_err), 0);
        tick(20);

        // 3-cycle glitch is dropped
        bus.seg_in = enc(5'd1);
        tick(3);
        bus.seg_in = enc(5'd0);
        tick(20);
        check("glitch_queue", 64'(exp_q.size()), 0);
        check("glitch_data", 64'(bus.data), 0);

        // Full count 0..31 then wrap to 0, 100 cycles each
        do_reset();
        pv_base = pv_seen;
        send_legal(5'd0, 100);
        for (int v = 1; v < 32; v++) send_legal(5'(v), 100);
        send_legal(5'd0, 100);
        check("count_pv_pulses", 64'(pv_seen - pv_base), 32);
        check("count_period", 64'(bus.period), 100);

        // Skip 3 -> 5 flags seq_err
        send_legal(5'd3, 30);
        send_legal(5'd5, 30);
        check("skip_data", 64'(bus.data), 5);

        // Blank is illegal once; data holds
        send_legal(5'd3, 30);
        send_illegal(8'h7F, 50);
        check("blank_data_hold", 64'(bus.data), 3);
        send_legal(5'd4, 30);
        check("after_blank_data", 64'(bus.data), 4);

        // Same value re-accepted after an illegal pattern is a seq_err
        send_illegal(8'hFF, 40);
        send_legal(5'd4, 30);

        // Reset mid-stream, then the held pattern is taken as first value
        bus.seg_in = enc(5'd1);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check_zero("midreset");
        tick(2);
        exp_have = 1'b0;
        exp_data = '0;
        exp_upd_cnt = 0;
        exp_err_cnt = 0;
        rst_n = 1'b1;
        push_legal(5'd1);
        tick(20);
        check("midreset_data", 64'(bus.data), 1);
        check("midreset_state", 64'(bus.state_dbg), 1);

        tick(10);
        check("queue_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end
endmodule
